// File: rtl/keypad_pkg.sv
// Shared keypad geometry, key-code constants and key-map helpers used by the
// scanner top level and its frame filter.
package keypad_pkg;

    localparam int KP_ROWS = 4;
    localparam int KP_COLS = 3;
    localparam int KP_KEYS = KP_ROWS * KP_COLS;

    typedef logic [KP_KEYS-1:0] key_map_t;

    localparam logic [3:0] KEY_1    = 4'd0;
    localparam logic [3:0] KEY_2    = 4'd1;
    localparam logic [3:0] KEY_3    = 4'd2;
    localparam logic [3:0] KEY_4    = 4'd3;
    localparam logic [3:0] KEY_5    = 4'd4;
    localparam logic [3:0] KEY_6    = 4'd5;
    localparam logic [3:0] KEY_7    = 4'd6;
    localparam logic [3:0] KEY_8    = 4'd7;
    localparam logic [3:0] KEY_9    = 4'd8;
    localparam logic [3:0] KEY_STAR = 4'd9;
    localparam logic [3:0] KEY_0    = 4'd10;
    localparam logic [3:0] KEY_HASH = 4'd11;

    // OR of set-bit indices; exact for a one-hot input and free of priority logic.
    function automatic logic [3:0] onehot_to_idx(input key_map_t vec);
        logic [3:0] idx;
        idx = 4'd0;
        for (int i = 0; i < KP_KEYS; i++) begin
            if (vec[i]) begin
                idx = idx | 4'(i);
            end else begin
                idx = idx;
            end
        end
        return idx;
    endfunction

    function automatic logic is_onehot(input key_map_t vec);
        return (vec != '0) && ((vec & (vec - 12'd1)) == '0);
    endfunction

endpackage

// File: rtl/kp_frame_filter.sv
// Debounces complete key frames into an accepted level map and raises a
// one-cycle press event when the map moves from idle to exactly one key.
module kp_frame_filter
    import keypad_pkg::*;
#(
    parameter int DEB_FRAMES = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       frame_valid_i,
    input  key_map_t   frame_i,
    output key_map_t   key_data_o,
    output logic       key_valid_o,
    output logic [3:0] key_code_o
);

    localparam int              ST_W   = $clog2(DEB_FRAMES);
    localparam logic [ST_W-1:0] ST_MAX = ST_W'(DEB_FRAMES - 1);

    key_map_t        cand_q, cand_d;
    key_map_t        key_data_q, key_data_d;
    logic [ST_W-1:0] stable_q, stable_d;
    logic            evt_q, evt_d;
    logic            key_valid_q, key_valid_d;
    logic [3:0]      key_code_q, key_code_d;

    // Candidate tracking, stable count and acceptance of the candidate.
    always_comb begin
        cand_d     = cand_q;
        stable_d   = stable_q;
        key_data_d = key_data_q;
        evt_d      = 1'b0;
        if (frame_valid_i) begin
            if (frame_i == cand_q) begin
                stable_d = (stable_q == ST_MAX) ? ST_MAX : stable_q + 1'b1;
                if ((stable_d == ST_MAX) && (cand_q != key_data_q)) begin
                    key_data_d = cand_q;
                    evt_d      = (key_data_q == '0) && is_onehot(cand_q);
                end else begin
                    key_data_d = key_data_q;
                end
            end else begin
                cand_d   = frame_i;
                stable_d = '0;
            end
        end else begin
            cand_d = cand_q;
        end
    end

    // The event is flagged on the update clock and published one clock later.
    always_comb begin
        key_valid_d = evt_q;
        if (evt_q) begin
            key_code_d = onehot_to_idx(key_data_q);
        end else begin
            key_code_d = key_code_q;
        end
    end

    // Filter state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cand_q      <= '0;
            stable_q    <= '0;
            key_data_q  <= '0;
            evt_q       <= 1'b0;
            key_valid_q <= 1'b0;
            key_code_q  <= 4'd0;
        end else begin
            cand_q      <= cand_d;
            stable_q    <= stable_d;
            key_data_q  <= key_data_d;
            evt_q       <= evt_d;
            key_valid_q <= key_valid_d;
            key_code_q  <= key_code_d;
        end
    end

    assign key_data_o  = key_data_q;
    assign key_valid_o = key_valid_q;
    assign key_code_o  = key_code_q;

endmodule

// File: rtl/keypad_event_scan.sv
// 3x4 keypad scanner: column drive, row synchronisation and frame assembly,
// feeding the debounce/event filter.
module keypad_event_scan
    import keypad_pkg::*;
#(
    parameter int SCAN_DIV   = 1000,
    parameter int DEB_FRAMES = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [3:0]  key_row,
    output logic [2:0]  key_col,
    output logic [11:0] key_data,
    output logic        key_valid,
    output logic [3:0]  key_code
);

    localparam int              CNT_W    = $clog2(SCAN_DIV);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SCAN_DIV - 1);

    logic [3:0]       row_s1_q, row_s2_q;
    logic [CNT_W-1:0] slot_q, slot_d;
    logic [2:0]       col_q, col_d;
    logic [1:0]       col_idx_q, col_idx_d;
    key_map_t         frame_q, frame_d, frame_new_s;
    logic             slot_last_s, frame_done_s;

    assign slot_last_s  = (slot_q == CNT_LAST);
    assign frame_done_s = slot_last_s && (col_idx_q == 2'd2);

    // Current frame with the driven column's bits replaced by the synced rows.
    always_comb begin
        frame_new_s = frame_q;
        for (int r = 0; r < KP_ROWS; r++) begin
            for (int c = 0; c < KP_COLS; c++) begin
                if (2'(c) == col_idx_q) begin
                    frame_new_s[r*KP_COLS+c] = row_s2_q[r];
                end else begin
                    frame_new_s[r*KP_COLS+c] = frame_q[r*KP_COLS+c];
                end
            end
        end
    end

    // Slot counter, column rotation and frame capture at the end of each slot.
    always_comb begin
        slot_d    = slot_q + 1'b1;
        col_d     = col_q;
        col_idx_d = col_idx_q;
        frame_d   = frame_q;
        if (slot_last_s) begin
            slot_d    = '0;
            col_d     = {col_q[1:0], col_q[2]};
            col_idx_d = (col_idx_q == 2'd2) ? 2'd0 : col_idx_q + 2'd1;
            frame_d   = frame_new_s;
        end else begin
            slot_d = slot_q + 1'b1;
        end
    end

    // Row synchroniser and scan state registers.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            row_s1_q  <= 4'd0;
            row_s2_q  <= 4'd0;
            slot_q    <= '0;
            col_q     <= 3'b001;
            col_idx_q <= 2'd0;
            frame_q   <= '0;
        end else begin
            row_s1_q  <= key_row;
            row_s2_q  <= row_s1_q;
            slot_q    <= slot_d;
            col_q     <= col_d;
            col_idx_q <= col_idx_d;
            frame_q   <= frame_d;
        end
    end

    assign key_col = col_q;

    kp_frame_filter #(
        .DEB_FRAMES (DEB_FRAMES)
    ) u_filter (
        .clk           (clk),
        .rst           (rst),
        .frame_valid_i (frame_done_s),
        .frame_i       (frame_new_s),
        .key_data_o    (key_data),
        .key_valid_o   (key_valid),
        .key_code_o    (key_code)
    );

endmodule

// File: tb/tb_keypad_event_scan.sv
// Self-checking bench for keypad_event_scan with a behavioural keypad matrix
// and a scoreboard of expected press codes.
module tb_keypad_event_scan;

    logic        clk;
    logic        rst;
    logic [3:0]  key_row;
    logic [2:0]  key_col;
    logic [11:0] key_data;
    logic        key_valid;
    logic [3:0]  key_code;

    logic [11:0] pressed;
    logic        row_force;
    logic [3:0]  exp_q[$];
    int          checks;
    int          errors;

    keypad_event_scan #(
        .SCAN_DIV   (4),
        .DEB_FRAMES (3)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .key_row   (key_row),
        .key_col   (key_col),
        .key_data  (key_data),
        .key_valid (key_valid),
        .key_code  (key_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Keypad matrix: a row reads high when a pressed key sits in a driven column.
    always_comb begin
        key_row = 4'h0;
        if (row_force) begin
            key_row = 4'hF;
        end else begin
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 3; c++) begin
                    if (pressed[r*3+c] && key_col[c]) key_row[r] = 1'b1;
                end
            end
        end
    end

    task automatic tick();
        logic [3:0] exp_code;
        @(posedge clk);
        @(negedge clk);
        if (key_valid !== 1'b0) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_pulse: key_valid=%b key_code=%0d, required no pulse", key_valid, key_code);
            end else begin
                exp_code = exp_q.pop_front();
                if (key_code !== exp_code) begin
                    errors++;
                    $display("FAIL press_code: key_code=%0d, required %0d", key_code, exp_code);
                end
            end
        end
    endtask

    task automatic do_reset(input logic [11:0] keys);
        rst = 1'b0;
        exp_q.delete();
        pressed = keys;
        tick();
        tick();
        rst = 1'b1;
    endtask

    task automatic test_reset();
        logic [2:0] exp_col;
        rst = 1'b0;
        row_force = 1'b1;
        pressed = 12'h000;
        for (int i = 0; i < 5; i++) begin
            tick();
            checks++;
            if ({key_col, key_data, key_valid} !== {3'b001, 12'h000, 1'b0}) begin
                errors++;
                $display("FAIL reset_state: col=%b data=%h valid=%b, required 001/000/0", key_col, key_data, key_valid);
            end
        end
        row_force = 1'b0;
        rst = 1'b1;
        for (int i = 0; i < 12; i++) begin
            exp_col = 3'b001 << (i / 4);
            checks++;
            if (key_col !== exp_col) begin
                errors++;
                $display("FAIL col_order: clock %0d key_col=%b, required %b", i, key_col, exp_col);
            end
            tick();
        end
    endtask

    task automatic test_clean_press();
        do_reset(12'h010);
        exp_q.push_back(4'd4);
        repeat (35) tick();
        checks++;
        if (key_data !== 12'h000) begin
            errors++;
            $display("FAIL press5_early: key_data=%h, required 000", key_data);
        end
        tick();
        checks++;
        if (key_data !== 12'h010) begin
            errors++;
            $display("FAIL press5_accept: key_data=%h, required 010", key_data);
        end
        repeat (12) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL press5_pulse: %0d pulse(s) missing, required 0", exp_q.size());
        end
        pressed = 12'h000;
        repeat (35) tick();
        checks++;
        if (key_data !== 12'h010) begin
            errors++;
            $display("FAIL release5_hold: key_data=%h, required 010", key_data);
        end
        tick();
        checks++;
        if (key_data !== 12'h000) begin
            errors++;
            $display("FAIL release5_clear: key_data=%h, required 000", key_data);
        end
        repeat (12) tick();
    endtask

    task automatic test_bounce();
        logic moved;
        moved = 1'b0;
        do_reset(12'h001);
        for (int i = 0; i < 48; i++) begin
            if (i > 0 && (i % 5) == 0) pressed[0] = ~pressed[0];
            tick();
            if (key_data !== 12'h000) moved = 1'b1;
        end
        checks++;
        if (moved !== 1'b0) begin
            errors++;
            $display("FAIL bounce_hold: key_data moved during bounce, last=%h, required 000", key_data);
        end
        pressed = 12'h001;
        exp_q.push_back(4'd0);
        repeat (35) tick();
        checks++;
        if (key_data !== 12'h000) begin
            errors++;
            $display("FAIL bounce_early: key_data=%h, required 000", key_data);
        end
        tick();
        checks++;
        if (key_data !== 12'h001) begin
            errors++;
            $display("FAIL bounce_accept: key_data=%h, required 001", key_data);
        end
        repeat (12) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL bounce_pulse: %0d pulse(s) missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_multi_key();
        do_reset(12'hA00);
        repeat (48) tick();
        checks++;
        if (key_data !== 12'hA00) begin
            errors++;
            $display("FAIL multi_accept: key_data=%h, required a00", key_data);
        end
        pressed = 12'h800;
        repeat (48) tick();
        checks++;
        if (key_data !== 12'h800) begin
            errors++;
            $display("FAIL multi_release_star: key_data=%h, required 800", key_data);
        end
    endtask

    task automatic test_reset_mid_scan();
        do_reset(12'h400);
        exp_q.push_back(4'd10);
        repeat (30) tick();
        rst = 1'b0;
        #1;
        checks++;
        if ({key_col, key_data, key_valid, key_code} !== {3'b001, 12'h000, 1'b0, 4'd0}) begin
            errors++;
            $display("FAIL mid_reset_clear: col=%b data=%h valid=%b code=%0d, required 001/000/0/0",
                     key_col, key_data, key_valid, key_code);
        end
        tick();
        rst = 1'b1;
        repeat (35) tick();
        checks++;
        if (key_data !== 12'h000) begin
            errors++;
            $display("FAIL mid_reset_early: key_data=%h, required 000", key_data);
        end
        tick();
        checks++;
        if (key_data !== 12'h400) begin
            errors++;
            $display("FAIL mid_reset_accept: key_data=%h, required 400", key_data);
        end
        repeat (12) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL mid_reset_pulse: %0d pulse(s) missing, required 0", exp_q.size());
        end
    endtask

    task automatic test_back_to_back();
        do_reset(12'h002);
        exp_q.push_back(4'd1);
        repeat (48) tick();
        checks++;
        if (key_data !== 12'h002) begin
            errors++;
            $display("FAIL b2b_first: key_data=%h, required 002", key_data);
        end
        pressed = 12'h004;
        repeat (35) tick();
        checks++;
        if (key_data !== 12'h002) begin
            errors++;
            $display("FAIL b2b_hold: key_data=%h, required 002", key_data);
        end
        tick();
        checks++;
        if (key_data !== 12'h004) begin
            errors++;
            $display("FAIL b2b_second: key_data=%h, required 004", key_data);
        end
        repeat (12) tick();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL b2b_pulse: %0d pulse(s) missing, required 0", exp_q.size());
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst = 1'b0;
        row_force = 1'b0;
        pressed = 12'h000;
        test_reset();
        test_clean_press();
        test_bounce();
        test_multi_key();
        test_reset_mid_scan();
        test_back_to_back();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
